// File: rtl/reg_share_arbiter_pkg.sv
// Shared types and defaults for the round-robin shared-register arbiter.
package reg_share_arbiter_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 8;

    // 2'd3 is unused; the FSM treats it as illegal and recovers to S_IDLE
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests/data in, grant/ack/register out.
interface reg_share_arbiter_if
    import reg_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [IDX_W-1:0]       owner;
    logic                   ack;
    logic                   busy;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       q_n;

    modport master (output req, wdata, input gnt, owner, ack, busy, q, q_n);
    modport slave  (input req, wdata, output gnt, owner, ack, busy, q, q_n);
endinterface

// File: rtl/shared_dff_reg.sv
// Shared WIDTH-bit register with load enable and a registered complement output.
module shared_dff_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            q_n <= '1;
        end else if (load) begin
            q   <= d;
            q_n <= ~d;
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter that commits one requester's data at a time into a shared register.
module reg_share_arbiter
    import reg_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    reg_share_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             ack_q, ack_d;
    logic             busy_q;
    logic [IDX_W-1:0] winner, cand;
    logic             found;
    logic             load;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] q_val, q_n_val;

    // Rotating priority search starting at ptr_q
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % int'(N_REQ));
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb sel_data = bus.wdata[int'(owner_q)*int'(WIDTH) +: WIDTH];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        ack_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (found) begin
                    gnt_d   = N_REQ'(1) << winner;
                    owner_d = winner;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                gnt_d   = '0;
                state_d = S_IDLE;
                // Owner still requesting commits; a dropped request is an abandon
                if (bus.req[owner_q]) begin
                    load    = 1'b1;
                    ack_d   = 1'b1;
                    ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    shared_dff_reg #(.WIDTH(WIDTH)) u_reg (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .d    (sel_data),
        .q    (q_val),
        .q_n  (q_n_val)
    );

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign bus.q     = q_val;
    assign bus.q_n   = q_n_val;

endmodule
